// File: rtl/data_memory_lsu.sv
// Data memory for the single-cycle RV32 core: byte-addressed, word-organised RAM
// with RV32I load/store sizing, fault detection and a sequential post-reset clear.
module data_memory_lsu #(
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  WE,
  input  logic                  RE,
  input  logic [2:0]            FUNCT3,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic                  ERR,
  output logic                  BUSY
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          fault;
  logic          clear_en;
  logic          store_en;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign idx  = A[IW+1:2];
  assign lane = A[1:0];

  generate
    if (ADDR_WIDTH > IW + 2) begin : g_range
      assign out_of_range = |A[ADDR_WIDTH-1:IW+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fault = 1'b0;
    unique case (FUNCT3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = A[0];
      F3_W:        fault = |A[1:0];
      default:     fault = 1'b1;
    endcase
    fault = fault | out_of_range;
  end

  assign BUSY     = (state == ST_CLEAR) | RST;
  assign ERR      = (WE | RE) & fault & ~BUSY;
  assign clear_en = (state == ST_CLEAR) & ~RST;
  assign store_en = WE & ~fault & ~BUSY;

  // Narrow store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    be    = 4'b1111;
    wdata = WD;
    unique case (FUNCT3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        be    = A[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WD;
      end
    endcase
  end

  // NOTE: the array has no reset branch; the clear engine zeroes it one word per cycle.
  always_ff @(posedge CLK) begin
    if (clear_en) begin
      mem[ptr] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == ST_CLEAR) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == {IW{1'b1}}) state_nxt = ST_READY;
    end
  end

  assign word     = mem[idx];
  assign byte_sel = word[8*lane +: 8];
  assign half_sel = A[1] ? word[31:16] : word[15:0];

  always_comb begin
    RD = '0;
    unique case (FUNCT3)
      F3_B:    RD = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   RD = {24'h0, byte_sel};
      F3_H:    RD = {{16{half_sel[15]}}, half_sel};
      F3_HU:   RD = {16'h0, half_sel};
      F3_W:    RD = word;
      default: RD = '0;
    endcase
    if (fault || BUSY) RD = '0;
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: clear engine timing, sized stores/loads, faults,
// write timing and the CLEAR_ON_RESET=0 variant, scoreboard-driven.
module tb_data_memory_lsu;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk, rst, rst0;
  logic [31:0] a;
  logic        we, re;
  logic [2:0]  f3;
  logic [31:0] wd;
  logic [31:0] rd, rd0;
  logic        err, err0, busy, busy0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } txn_t;

  txn_t sb[$];

  data_memory_lsu #(.DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(clk), .RST(rst), .A(a), .WE(we), .RE(re), .FUNCT3(f3), .WD(wd),
    .RD(rd), .ERR(err), .BUSY(busy)
  );

  data_memory_lsu #(.DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut0 (
    .CLK(clk), .RST(rst0), .A(a), .WE(we), .RE(re), .FUNCT3(f3), .WD(wd),
    .RD(rd0), .ERR(err0), .BUSY(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic txn_t mk(input logic [31:0] ai, input logic wei, input logic rei,
                              input logic [2:0] f3i, input logic [31:0] wdi,
                              input logic [31:0] rdi, input logic erri);
    txn_t t;
    t.a = ai; t.we = wei; t.re = rei; t.f3 = f3i; t.wd = wdi; t.rd = rdi; t.err = erri;
    return t;
  endfunction

  task automatic drive(input logic [31:0] ai, input logic wei, input logic rei,
                       input logic [2:0] f3i, input logic [31:0] wdi);
    a = ai; we = wei; re = rei; f3 = f3i; wd = wdi;
  endtask

  task automatic test_reset();
    int   n;
    txn_t t[$];
    txn_t e;
    rst = 1'b1; rst0 = 1'b1;
    drive(32'h400, 1'b0, 1'b1, LW, 32'h0);
    @(negedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || rd !== 32'h0 || err !== 1'b0 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_cycle: busy=%b rd=%h err=%b busy0=%b, want 1/0/0/1", busy, rd, err, busy0);
    end
    @(negedge clk);
    rst = 1'b0; rst0 = 1'b0;
    drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
      if (n == 200) begin
        drive(32'h0, 1'b1, 1'b0, LW, 32'h12345678);
        #1;
        total++;
        if (err !== 1'b0 || rd !== 32'h0) begin
          bad++;
          $display("FAIL store_during_busy: err=%b rd=%h, want 0/0", err, rd);
        end
      end
      if (n == 201) drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
    end
    total++;
    if (n !== 256) begin
      bad++;
      $display("FAIL clear_length: busy dropped after %0d edges, want 256", n);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL no_clear_busy: busy0=%b, want 0", busy0);
    end
    @(negedge clk);
    t.push_back(mk(32'h000, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    t.push_back(mk(32'h3FC, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    t.push_back(mk(32'h200, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    foreach (t[k]) begin
      drive(t[k].a, t[k].we, t[k].re, t[k].f3, t[k].wd);
      sb.push_back(t[k]);
      #2;
      e = sb.pop_front();
      total++;
      if (rd !== e.rd || err !== e.err) begin
        bad++;
        $display("FAIL post_clear[%0d]: rd=%h err=%b, want rd=%h err=%b", k, rd, err, e.rd, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_timing();
    txn_t e;
    drive(32'h40, 1'b1, 1'b1, LW, 32'hCAFEF00D);
    sb.push_back(mk(32'h40, 1'b1, 1'b1, LW, 32'hCAFEF00D, 32'h0, 1'b0));
    #2;
    e = sb.pop_front();
    total++;
    if (rd !== e.rd || err !== e.err) begin
      bad++;
      $display("FAIL write_before_edge: rd=%h err=%b, want rd=%h err=%b", rd, err, e.rd, e.err);
    end
    sb.push_back(mk(32'h40, 1'b1, 1'b1, LW, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (rd !== e.rd || err !== e.err) begin
      bad++;
      $display("FAIL write_after_edge: rd=%h err=%b, want rd=%h err=%b", rd, err, e.rd, e.err);
    end
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
  endtask

  task automatic test_byte_half();
    txn_t t[$];
    txn_t e;
    t.push_back(mk(32'h10, 1'b1, 1'b0, LW, 32'h11223344, 32'h0,        1'b0));
    t.push_back(mk(32'h11, 1'b1, 1'b0, LB, 32'h000000AA, 32'h0,        1'b0));
    t.push_back(mk(32'h12, 1'b1, 1'b0, LH, 32'h0000BEEF, 32'h0,        1'b0));
    t.push_back(mk(32'h10, 1'b0, 1'b1, LW, 32'h0,        32'hBEEFAA44, 1'b0));
    t.push_back(mk(32'h11, 1'b0, 1'b1, LBU, 32'h0,       32'h000000AA, 1'b0));
    foreach (t[k]) begin
      drive(t[k].a, t[k].we, t[k].re, t[k].f3, t[k].wd);
      sb.push_back(t[k]);
      #2;
      e = sb.pop_front();
      if (!e.we) begin
        total++;
        if (rd !== e.rd || err !== e.err) begin
          bad++;
          $display("FAIL byte_half[%0d]: rd=%h err=%b, want rd=%h err=%b", k, rd, err, e.rd, e.err);
        end
      end else begin
        total++;
        if (err !== e.err) begin
          bad++;
          $display("FAIL byte_half_store[%0d]: err=%b, want %b", k, err, e.err);
        end
      end
      @(negedge clk);
    end
    drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
  endtask

  task automatic test_extension();
    txn_t t[$];
    txn_t e;
    drive(32'h20, 1'b1, 1'b0, LW, 32'h80FF7F01);
    @(negedge clk);
    t.push_back(mk(32'h22, 1'b0, 1'b1, LB,  32'h0, 32'hFFFFFFFF, 1'b0));
    t.push_back(mk(32'h22, 1'b0, 1'b1, LBU, 32'h0, 32'h000000FF, 1'b0));
    t.push_back(mk(32'h21, 1'b0, 1'b1, LB,  32'h0, 32'h0000007F, 1'b0));
    t.push_back(mk(32'h22, 1'b0, 1'b1, LH,  32'h0, 32'hFFFF80FF, 1'b0));
    t.push_back(mk(32'h22, 1'b0, 1'b1, LHU, 32'h0, 32'h000080FF, 1'b0));
    t.push_back(mk(32'h23, 1'b0, 1'b1, LB,  32'h0, 32'hFFFFFF80, 1'b0));
    t.push_back(mk(32'h20, 1'b0, 1'b1, LH,  32'h0, 32'h00007F01, 1'b0));
    t.push_back(mk(32'h20, 1'b0, 1'b0, LW,  32'h0, 32'h80FF7F01, 1'b0));
    foreach (t[k]) begin
      drive(t[k].a, t[k].we, t[k].re, t[k].f3, t[k].wd);
      sb.push_back(t[k]);
      #2;
      e = sb.pop_front();
      total++;
      if (rd !== e.rd || err !== e.err) begin
        bad++;
        $display("FAIL extension[%0d]: rd=%h err=%b, want rd=%h err=%b", k, rd, err, e.rd, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_faults();
    txn_t t[$];
    txn_t e;
    drive(32'h04, 1'b1, 1'b0, LW, 32'hDEADBEEF);
    @(negedge clk);
    t.push_back(mk(32'h005, 1'b1, 1'b0, LH,     32'h00001111, 32'h0, 1'b1));
    t.push_back(mk(32'h006, 1'b1, 1'b0, LW,     32'h22222222, 32'h0, 1'b1));
    t.push_back(mk(32'h008, 1'b1, 1'b0, 3'b011, 32'h33333333, 32'h0, 1'b1));
    t.push_back(mk(32'h400, 1'b1, 1'b0, LW,     32'h44444444, 32'h0, 1'b1));
    t.push_back(mk(32'h004, 1'b0, 1'b1, LW,     32'h0, 32'hDEADBEEF, 1'b0));
    t.push_back(mk(32'h008, 1'b0, 1'b1, LW,     32'h0, 32'h0,        1'b0));
    t.push_back(mk(32'h000, 1'b0, 1'b1, LW,     32'h0, 32'h0,        1'b0));
    t.push_back(mk(32'h005, 1'b0, 1'b1, LH,     32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h007, 1'b0, 1'b1, LHU,    32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h006, 1'b0, 1'b1, LW,     32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h004, 1'b0, 1'b1, 3'b011, 32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h004, 1'b0, 1'b1, 3'b110, 32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h004, 1'b0, 1'b1, 3'b111, 32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h400, 1'b0, 1'b1, LW,     32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h401, 1'b0, 1'b1, LBU,    32'h0, 32'h0,        1'b1));
    t.push_back(mk(32'h006, 1'b0, 1'b0, LW,     32'h0, 32'h0,        1'b0));
    t.push_back(mk(32'h3FC, 1'b0, 1'b1, LW,     32'h0, 32'h0,        1'b0));
    foreach (t[k]) begin
      drive(t[k].a, t[k].we, t[k].re, t[k].f3, t[k].wd);
      sb.push_back(t[k]);
      #2;
      e = sb.pop_front();
      total++;
      if (rd !== e.rd || err !== e.err) begin
        bad++;
        $display("FAIL faults[%0d]: rd=%h err=%b, want rd=%h err=%b", k, rd, err, e.rd, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_clear();
    txn_t e;
    drive(32'h80, 1'b1, 1'b0, LW, 32'h5A5AA5A5);
    @(negedge clk);
    drive(32'h84, 1'b1, 1'b0, LW, 32'h01020304);
    @(negedge clk);
    rst0 = 1'b1;
    drive(32'h84, 1'b1, 1'b0, LW, 32'hFFFFFFFF);
    #2;
    total++;
    if (busy0 !== 1'b1 || rd0 !== 32'h0 || err0 !== 1'b0) begin
      bad++;
      $display("FAIL no_clear_reset_cycle: busy0=%b rd0=%h err0=%b, want 1/0/0", busy0, rd0, err0);
    end
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    drive(32'h80, 1'b0, 1'b1, LW, 32'h0);
    sb.push_back(mk(32'h80, 1'b0, 1'b1, LW, 32'h0, 32'h5A5AA5A5, 1'b0));
    #1;
    e = sb.pop_front();
    total++;
    if (busy0 !== 1'b0 || rd0 !== e.rd || err0 !== e.err) begin
      bad++;
      $display("FAIL no_clear_retained: busy0=%b rd0=%h err0=%b, want 0 rd=%h err=%b",
               busy0, rd0, err0, e.rd, e.err);
    end
    @(posedge clk);
    #1;
    drive(32'h84, 1'b0, 1'b1, LW, 32'h0);
    sb.push_back(mk(32'h84, 1'b0, 1'b1, LW, 32'h0, 32'h01020304, 1'b0));
    #1;
    e = sb.pop_front();
    total++;
    if (busy0 !== 1'b0 || rd0 !== e.rd) begin
      bad++;
      $display("FAIL no_clear_store_dropped: busy0=%b rd0=%h, want 0 rd=%h", busy0, rd0, e.rd);
    end
    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
  endtask

  task automatic test_reset_mid_clear();
    int   n;
    txn_t t[$];
    txn_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    total++;
    if (n !== 100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_clear_reach: edges=%0d busy=%b, want 100/1", n, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    total++;
    if (n !== 256) begin
      bad++;
      $display("FAIL mid_clear_restart: busy dropped after %0d edges, want 256", n);
    end
    @(negedge clk);
    t.push_back(mk(32'h40, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    t.push_back(mk(32'h10, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    t.push_back(mk(32'h20, 1'b0, 1'b1, LW, 32'h0, 32'h0, 1'b0));
    foreach (t[k]) begin
      drive(t[k].a, t[k].we, t[k].re, t[k].f3, t[k].wd);
      sb.push_back(t[k]);
      #2;
      e = sb.pop_front();
      total++;
      if (rd !== e.rd || err !== e.err) begin
        bad++;
        $display("FAIL mid_clear_zero[%0d]: rd=%h err=%b, want rd=%h err=%b", k, rd, err, e.rd, e.err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    drive(32'h0, 1'b0, 1'b0, LW, 32'h0);
    test_reset();
    test_write_timing();
    test_byte_half();
    test_extension();
    test_faults();
    test_no_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Next-generation data memory for the single-cycle RV32 core.
- Byte-addressed, word-organised RAM with RV32I load/store sizing (byte, half and word access), sign/zero extension, byte-lane writes, and detection of misaligned, illegal and out-of-range accesses.
- A reset-driven sequential clear engine zeroes the array one word per cycle and reports BUSY, so no single-cycle full-array reset is needed.
- Sits between the ALU result/rs2 path and the writeback mux.

Parameters:
- DEPTH, 256, number of 32-bit words. Must be a power of 2 and at least 2.
- ADDR_WIDTH, 32, width of the byte address A.
- CLEAR_ON_RESET, 1. If 1, the array is zeroed after reset. If 0, the clear is skipped and array contents are retained.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  ADDR_WIDTH  byte address.
- WE  input  1  store request.
- RE  input  1  load request. Used to qualify ERR only; RD is always driven.
- FUNCT3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- WD  input  32  store data. Low bits are used for B and H.
- RD  output  32  load data, extended per FUNCT3. Combinational.
- ERR  output  1  access fault on the current request. Combinational.
- BUSY  output  1  clear engine active. Accesses are blocked while high.

Behaviour:
- Word index is A[log2(DEPTH)+1:2]. Byte lane is A[1:0].
- The address is out of range if any bit of A above log2(DEPTH)+1 is nonzero.
- A fault exists when any of these is true:
  - FUNCT3 is 011, 110 or 111.
  - H/HU with A[0]=1.
  - W with A[1:0]≠0.
  - Address out of range.
- ERR = (WE|RE) & fault & !BUSY.
- Stores, committed at the rising edge when WE=1, no fault, BUSY=0 and RST=0:
  - B writes WD[7:0] to lane A[1:0].
  - H writes WD[15:0] to lanes {A[1],0} and {A[1],1}.
  - W writes all four lanes.
  - Other lanes are untouched.
  - A faulting or blocked store writes nothing.
- Loads (combinational, no WE/RE gating):
  - Fetch word W = mem[index].
  - B: sign-extend the selected byte. BU: zero-extend it.
  - H: sign-extend the selected halfword. HU: zero-extend it.
  - W: return the whole word.
  - RD=0 on fault or while BUSY.
- Read-during-write: RD shows the old contents until the write edge and the new contents after it. There is no bypass.
- Clear FSM, states CLEAR and READY, with pointer ptr of log2(DEPTH) bits:
  - RST=1: next state CLEAR (READY if CLEAR_ON_RESET=0), ptr←0. BUSY=1 during the reset cycle(s).
  - CLEAR: mem[ptr]←0, ptr←ptr+1. After the write with ptr=DEPTH-1, go to READY. ptr wraps to 0 and is unused afterwards.
  - READY: BUSY=0. Stays in READY until RST.
- BUSY = (state==CLEAR) | RST. It deasserts exactly DEPTH rising edges after RST falls; with CLEAR_ON_RESET=0 it deasserts 0 edges after.
- RST asserted mid-clear restarts the clear at ptr=0. RST asserted in READY re-enters CLEAR. A store in the same cycle as RST is dropped.
- Reset-cycle values: RD=0, ERR=0, BUSY=1.
- Post-reset values: RD=0 for all in-range addresses once the clear completes.
- No X propagation: RD never returns uninitialised contents when CLEAR_ON_RESET=1.

Test Plan:
- Reset/clear (DEPTH=256): pulse RST 1 cycle -> BUSY=1 for 256 edges after release, then 0. Any LW returns 0. A SW issued during BUSY is not committed and ERR=0.
- Byte/half stores: SW 0x11223344 @0x10, then SB 0xAA @0x11, then SH 0xBEEF @0x12 -> LW @0x10 = 0xBEEFAA44.
- Extension: word 0x80FF7F01 @0x20 ->
  - LB @0x22 = 0xFFFFFFFF.
  - LBU @0x22 = 0x000000FF.
  - LB @0x21 = 0x0000007F.
  - LH @0x22 = 0xFFFF80FF.
  - LHU @0x22 = 0x000080FF.
- Faults: SH @0x05, SW @0x06, FUNCT3=011, A=0x400 with DEPTH=256 -> ERR=1 with WE=1, memory unchanged; the same faulting addresses as loads give ERR=1 with RE=1 and RD=0.
- Reset mid-clear: assert RST at ptr=100 -> BUSY stays high and is released 256 edges after the second RST falls. With CLEAR_ON_RESET=0, data written before reset survives and BUSY=0 on the first edge after release.
- Write timing: SW 0xCAFEF00D @0x40 -> RD (LW @0x40) shows the old value before the edge and 0xCAFEF00D after it.
